seg_scan_mux: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-electrode 7-segment display.

---
 rtl/seg_scan_pkg.sv | 13 +
 rtl/seg_scan_prescaler.sv | 29 ++
 rtl/seg_scan_mux.sv | 128 ++++++++++++
 tb/tb_seg_scan_mux.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan multiplexer.
package seg_scan_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_prescaler.sv
// Cycle counter 0..LIMIT-1 with synchronous clear; terminal is high on the last count.
module seg_scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic terminal
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= terminal ? '0 : cnt_q + 1'b1;
    end
  end

  assign terminal = (cnt_q == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Scan controller for an N-digit multiplexed 7-segment display (IDLE/DRIVE/GUARD).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          blank,
  output logic [DIGIT_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  index_q;
  logic [CODE_W-1:0] shadow_q, active_q;
  logic              blank_q;
  logic              drive_run, guard_run;
  logic              drive_term, guard_term;
  logic              slot_end, wrap;
  logic              lz_blank;
  logic [DIGIT_W-1:0] cur_code;

  assign drive_run = enable && (state_q == DRIVE);
  assign guard_run = enable && (state_q == GUARD);
  assign slot_end  = guard_run && guard_term;
  assign wrap      = slot_end && (index_q == LAST_IDX);

  // Counters are held clear outside their own state, so every slot starts at zero.
  seg_scan_prescaler #(.LIMIT(SCAN_DIV)) u_drive_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (!drive_run),
    .count    (drive_run),
    .terminal (drive_term)
  );

  seg_scan_prescaler #(.LIMIT(GUARD_CYCLES)) u_guard_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (!guard_run),
    .count    (guard_run),
    .terminal (guard_term)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = DRIVE;
        DRIVE:   if (drive_term) state_d = GUARD;
        GUARD:   if (guard_term) state_d = DRIVE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable || (state_q == IDLE)) begin
      index_q <= '0;
    end else if (slot_end) begin
      index_q <= (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
    end
  end

  // Active digits only change at scan start or frame wrap, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= {NUM_DIGITS{BLANK_CODE}};
      active_q <= {NUM_DIGITS{BLANK_CODE}};
      blank_q  <= 1'b0;
    end else begin
      if (load) shadow_q <= digits_in;
      if ((enable && (state_q == IDLE)) || wrap) active_q <= shadow_q;
      blank_q <= blank;
    end
  end

  assign cur_code = active_q[index_q*DIGIT_W +: DIGIT_W];

`ifdef LEADING_ZERO_BLANK_EN
  // zero_run[i] is set when digit i and every digit above it hold zero.
  logic [NUM_DIGITS:0] zero_run;
  always_comb begin
    zero_run = '0;
    zero_run[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run[i] = zero_run[i+1] && (active_q[i*DIGIT_W +: DIGIT_W] == '0);
    end
  end
  assign lz_blank = (index_q != '0) && zero_run[index_q];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    digit_sel  = '0;
    digit_code = BLANK_CODE;
    frame_done = 1'b0;
    if (state_q == DRIVE) begin
      digit_sel[index_q] = 1'b1;
      digit_code = (blank_q || lz_blank) ? BLANK_CODE : cur_code;
      frame_done = drive_term && (index_q == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYCLES=1.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic        blank;
  logic [3:0]  digit_code;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_mux #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .GUARD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .blank      (blank),
    .digit_code (digit_code),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] sel,
                           input logic [3:0] code, input logic fd);
    check({tag, "_sel"},  32'(digit_sel),  32'(sel));
    check({tag, "_code"}, 32'(digit_code), 32'(code));
    check({tag, "_fd"},   32'(frame_done), 32'(fd));
  endtask

  // One 20-cycle frame: 4 digits x (4 drive + 1 guard). Optional load/blank injection
  // and an early stop (kind 1 = drop enable, kind 2 = assert rst) after cycle stop_at.
  task automatic run_frame(input string tag, input logic [15:0] shown,
                           input int load_at, input logic [15:0] load_val,
                           input int blank_at, input int stop_at, input int stop_kind);
    logic bq;
    bq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      int d;
      int k;
      d = c / 5;
      k = c % 5;
      @(negedge clk);
      if (k < 4)
        check_out($sformatf("%s_c%0d", tag, c), 4'(1 << d),
                  bq ? 4'hF : shown[d*4 +: 4], (d == 3) && (k == 3));
      else
        check_out($sformatf("%s_c%0d", tag, c), 4'b0000, 4'hF, 1'b0);
      load = (c == load_at);
      if (c == load_at) digits_in = load_val;
      blank = (blank_at >= 0) && (c >= blank_at) && (c < blank_at + 3);
      bq = blank;
      if (c == stop_at) begin
        if (stop_kind == 1) enable = 1'b0;
        else rst = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; blank = 1'b0; digits_in = '0;
    repeat (2) @(negedge clk);
    check_out("reset", 4'b0000, 4'hF, 1'b0);
    rst = 1'b0; enable = 1'b1;

    // Power-up with no load: blank codes on every digit.
    run_frame("t1", 16'hFFFF, -1, 16'h0, -1, -1, 0);

    // Load while idle, then scan.
    enable = 1'b0;
    @(negedge clk);
    check_out("idle_a", 4'b0000, 4'hF, 1'b0);
    load = 1'b1; digits_in = 16'h4321;
    @(negedge clk);
    load = 1'b0;
    check_out("idle_b", 4'b0000, 4'hF, 1'b0);
    enable = 1'b1;
    run_frame("t2a", 16'h4321, -1, 16'h0, -1, -1, 0);
    run_frame("t2b", 16'h4321, -1, 16'h0, -1, -1, 0);

    // Mid-frame load shows next frame; load on the wrap edge is one frame later.
    run_frame("t3a", 16'h4321, 7,  16'h8765, -1, -1, 0);
    run_frame("t3b", 16'h8765, 19, 16'h2468, -1, -1, 0);
    run_frame("t3c", 16'h8765, -1, 16'h0,    -1, -1, 0);
    run_frame("t3d", 16'h2468, -1, 16'h0,    -1, -1, 0);

    // Blank for 3 cycles starting at digit 2's first drive cycle.
    run_frame("t4", 16'h2468, -1, 16'h0, 10, -1, 0);

    // Disable mid-DRIVE of digit 1, then re-enable.
    run_frame("t5a", 16'h2468, -1, 16'h0, -1, 6, 1);
    @(negedge clk);
    check_out("dis_a", 4'b0000, 4'hF, 1'b0);
    @(negedge clk);
    check_out("dis_b", 4'b0000, 4'hF, 1'b0);
    enable = 1'b1;
    run_frame("t5b", 16'h2468, -1, 16'h0, -1, -1, 0);

    // Reset during the guard after digit 0: shadow is lost.
    run_frame("t5c", 16'h2468, -1, 16'h0, -1, 4, 2);
    @(negedge clk);
    check_out("rst_mid", 4'b0000, 4'hF, 1'b0);
    rst = 1'b0;
    run_frame("t5d", 16'hFFFF, -1, 16'h0, -1, -1, 0);

    // Leading-zero handling.
    run_frame("t6a", 16'hFFFF, 5, 16'h0050, -1, -1, 0);
`ifdef LEADING_ZERO_BLANK_EN
    run_frame("t6b", 16'hFF50, 5, 16'h0000, -1, -1, 0);
    run_frame("t6c", 16'hFFF0, -1, 16'h0,   -1, -1, 0);
`else
    run_frame("t6b", 16'h0050, 5, 16'h0000, -1, -1, 0);
    run_frame("t6c", 16'h0000, -1, 16'h0,   -1, -1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
